// File: rtl/router_1xn_if.sv
// Byte-stream side and per-channel read side of the 1-to-N packet router.
// The router connects through the slave modport and the traffic source/sink through master.
interface router_1xn_if #(
  parameter int DATA_W    = 8,
  parameter int NUM_PORTS = 3
);
  logic                        pkt_valid;
  logic [DATA_W-1:0]           data_in;
  logic [NUM_PORTS-1:0]        read_enb;
  logic [NUM_PORTS*DATA_W-1:0] data_out;
  logic [NUM_PORTS-1:0]        valid_out;
  logic                        busy;
  logic                        error;
  logic                        drop;
  logic [NUM_PORTS-1:0]        soft_reset;

  modport master (
    output pkt_valid, data_in, read_enb,
    input  data_out, valid_out, busy, error, drop, soft_reset
  );

  modport slave (
    input  pkt_valid, data_in, read_enb,
    output data_out, valid_out, busy, error, drop, soft_reset
  );
endinterface

// File: rtl/router_1xn.sv
// 1-to-N packet router: decodes header bytes, checks parity and queues each packet in a
// per-channel FIFO; a channel left unread for TIMEOUT cycles is flushed.
module router_1xn #(
  parameter int DATA_W     = 8,
  parameter int NUM_PORTS  = 3,
  parameter int FIFO_DEPTH = 16,
  parameter int TIMEOUT    = 30
) (
  input  logic          clock,
  input  logic          resetn,
  router_1xn_if.slave   bus
);

  localparam int ADDR_W = $clog2(NUM_PORTS);
  localparam int LEN_W  = DATA_W - ADDR_W;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int TCNT_W = $clog2(TIMEOUT + 1);

  localparam logic [1:0] S_DECODE      = 2'd0;
  localparam logic [1:0] S_LOAD_DATA   = 2'd1;
  localparam logic [1:0] S_LOAD_PARITY = 2'd2;
  localparam logic [1:0] S_DROP        = 2'd3;

  localparam logic [LEN_W:0] ONE_R = (LEN_W + 1)'(1);

  logic [1:0]           r_state;
  logic [ADDR_W-1:0]    r_addr;
  logic [LEN_W-1:0]     r_count;
  logic [LEN_W:0]       r_remain;
  logic [DATA_W-1:0]    r_parity;
  logic                 r_error;
  logic                 r_drop;
  logic [NUM_PORTS-1:0] r_soft_reset;

  logic [ADDR_W-1:0]           w_hdr_addr;
  logic [LEN_W-1:0]            w_hdr_len;
  logic                        w_hdr_ok;
  logic [ADDR_W-1:0]           w_target;
  logic                        w_target_full;
  logic                        w_target_flush;
  logic                        w_writing;
  logic                        w_busy;
  logic                        w_accept;
  logic [LEN_W:0]              w_left;
  logic [NUM_PORTS-1:0]        w_full;
  logic [NUM_PORTS-1:0]        w_flush;
  logic [NUM_PORTS-1:0]        w_wr_en;
  logic [NUM_PORTS-1:0]        w_valid_out;
  logic [NUM_PORTS*DATA_W-1:0] w_data_out;

  assign w_hdr_addr = bus.data_in[ADDR_W-1:0];
  assign w_hdr_len  = bus.data_in[DATA_W-1:ADDR_W];
  assign w_hdr_ok   = (int'(w_hdr_addr) < NUM_PORTS);
  assign w_target   = (r_state == S_DECODE) ? w_hdr_addr : r_addr;

  // An out-of-range header address selects no channel, so it never looks full or flushed.
  always_comb begin
    w_target_full  = 1'b0;
    w_target_flush = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (w_target == ADDR_W'(i)) begin
        w_target_full  = w_full[i];
        w_target_flush = w_flush[i];
      end
    end
  end

  assign w_writing = (r_state == S_LOAD_DATA) || (r_state == S_LOAD_PARITY) ||
                     ((r_state == S_DECODE) && w_hdr_ok);
  assign w_busy    = w_target_full &&
                     ((r_state == S_LOAD_DATA) || (r_state == S_LOAD_PARITY) ||
                      ((r_state == S_DECODE) && bus.pkt_valid && w_hdr_ok));
  assign w_accept  = bus.pkt_valid && !w_busy;

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      w_wr_en[i] = w_accept && w_writing && (w_target == ADDR_W'(i)) && !w_flush[i];
    end
  end

  // Bytes of the current packet still to arrive after an abort; a byte accepted at the flush edge counts as consumed.
  always_comb begin
    w_left = ONE_R;
    if (r_state == S_LOAD_DATA) begin
      w_left = {1'b0, r_count} + ONE_R;
    end
    if (w_accept) begin
      w_left = w_left - ONE_R;
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      r_state      <= S_DECODE;
      r_addr       <= '0;
      r_count      <= '0;
      r_remain     <= '0;
      r_parity     <= '0;
      r_error      <= 1'b0;
      r_drop       <= 1'b0;
      r_soft_reset <= '0;
    end else begin
      r_error      <= 1'b0;
      r_drop       <= 1'b0;
      r_soft_reset <= w_flush;
      case (r_state)
        S_DECODE: begin
          if (w_accept) begin
            if (!w_hdr_ok || w_target_flush) begin
              r_drop   <= 1'b1;
              r_remain <= {1'b0, w_hdr_len} + ONE_R;
              r_state  <= S_DROP;
            end else begin
              r_addr   <= w_hdr_addr;
              r_count  <= w_hdr_len;
              r_parity <= bus.data_in;
              r_state  <= (w_hdr_len != '0) ? S_LOAD_DATA : S_LOAD_PARITY;
            end
          end
        end
        S_LOAD_DATA: begin
          if (w_target_flush) begin
            r_drop   <= 1'b1;
            r_remain <= w_left;
            r_state  <= S_DROP;
          end else if (w_accept) begin
            r_parity <= r_parity ^ bus.data_in;
            r_count  <= r_count - LEN_W'(1);
            if (r_count == LEN_W'(1)) begin
              r_state <= S_LOAD_PARITY;
            end
          end
        end
        S_LOAD_PARITY: begin
          if (w_target_flush) begin
            r_drop   <= 1'b1;
            r_remain <= w_left;
            r_state  <= (w_left == '0) ? S_DECODE : S_DROP;
          end else if (w_accept) begin
            r_error <= (bus.data_in != r_parity);
            r_state <= S_DECODE;
          end
        end
        default: begin
          if (w_accept) begin
            r_remain <= r_remain - ONE_R;
            if (r_remain == ONE_R) begin
              r_state <= S_DECODE;
            end
          end
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_PORTS; g++) begin : g_chan
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W:0]    r_wptr;
    logic [PTR_W:0]    r_rptr;
    logic [TCNT_W-1:0] r_tcnt;
    logic              w_empty;
    logic              w_pop;
    logic              w_stall;

    // The extra pointer bit separates full (MSBs differ) from empty (pointers equal).
    assign w_empty           = (r_wptr == r_rptr);
    assign w_full[g]         = (r_wptr[PTR_W] != r_rptr[PTR_W]) &&
                               (r_wptr[PTR_W-1:0] == r_rptr[PTR_W-1:0]);
    assign w_valid_out[g]    = !w_empty;
    assign w_data_out[g*DATA_W +: DATA_W] = w_empty ? '0 : r_mem[r_rptr[PTR_W-1:0]];
    assign w_pop             = bus.read_enb[g] && !w_empty;
    assign w_stall           = !w_empty && !bus.read_enb[g];
    assign w_flush[g]        = w_stall && (r_tcnt == TCNT_W'(TIMEOUT - 1));

    always_ff @(posedge clock) begin
      if (w_wr_en[g]) begin
        r_mem[r_wptr[PTR_W-1:0]] <= bus.data_in;
      end
    end

    always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_tcnt <= '0;
      end else if (w_flush[g]) begin
        r_wptr <= '0;
        r_rptr <= '0;
        r_tcnt <= '0;
      end else begin
        if (w_wr_en[g]) begin
          r_wptr <= r_wptr + (PTR_W + 1)'(1);
        end
        if (w_pop) begin
          r_rptr <= r_rptr + (PTR_W + 1)'(1);
        end
        r_tcnt <= w_stall ? r_tcnt + TCNT_W'(1) : '0;
      end
    end
  end

  assign bus.valid_out  = w_valid_out;
  assign bus.data_out   = w_data_out;
  assign bus.busy       = w_busy;
  assign bus.error      = r_error;
  assign bus.drop       = r_drop;
  assign bus.soft_reset = r_soft_reset;

endmodule

// File: tb/tb_router_1xn.sv
// Self-checking bench for router_1xn: a packet table plus hand-written sequences for
// backpressure, channel timeout and asynchronous reset; channel words go through a scoreboard.
module tb_router_1xn;
  localparam int DATA_W     = 8;
  localparam int NUM_PORTS  = 3;
  localparam int FIFO_DEPTH = 16;
  localparam int TIMEOUT    = 30;
  localparam int NVEC       = 8;

  logic clock = 1'b0;
  logic resetn;
  always #5 clock = ~clock;

  router_1xn_if #(.DATA_W(DATA_W), .NUM_PORTS(NUM_PORTS)) ifc ();

  router_1xn #(
    .DATA_W(DATA_W), .NUM_PORTS(NUM_PORTS), .FIFO_DEPTH(FIFO_DEPTH), .TIMEOUT(TIMEOUT)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (ifc.slave)
  );

  typedef struct {
    logic [7:0] bytes [6];
    int         n;
    int         chan;
    int         expErr;
    int         expDrop;
  } vec_t;

  vec_t vecs [NVEC];
  logic [7:0] expQ [NUM_PORTS][$];
  logic [NUM_PORTS-1:0] rdMask = '0;
  int checksTotal = 0;
  int checksPassed = 0;
  int errCount = 0;
  int dropCount = 0;
  int softCount = 0;
  int acceptCount = 0;

  assign ifc.read_enb = rdMask;

  // Any comparison routes through here so the totals stay honest.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checksTotal++;
    if (actual === expected) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%0h, want 0x%0h", name, actual, expected);
  endtask

  // Pulse counters and the scoreboard side: every popped word must match the oldest expected one.
  always @(negedge clock) begin
    if (resetn) begin
      if (ifc.error) errCount++;
      if (ifc.drop) dropCount++;
      if (ifc.pkt_valid && !ifc.busy) acceptCount++;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (ifc.soft_reset[i]) softCount++;
        if (ifc.read_enb[i] && ifc.valid_out[i]) begin
          if (expQ[i].size() == 0)
            checkOutput($sformatf("ch%0d_pending", i), 32'(expQ[i].size()), 1);
          else
            checkOutput($sformatf("ch%0d_data", i), 32'(ifc.data_out[i*DATA_W +: DATA_W]),
                        32'(expQ[i].pop_front()));
        end
      end
    end
  end

  task automatic applyStimulus(input logic [7:0] b, input int chan, input bit track);
    int guard;
    bit done;
    guard = 0;
    done = 1'b0;
    ifc.pkt_valid = 1'b1;
    ifc.data_in = b;
    while (!done) begin
      @(negedge clock);
      done = !ifc.busy;
      @(posedge clock);
      if (done && track) expQ[chan].push_back(b);
      #1;
      guard++;
      if (!done && guard > 500) begin
        checkOutput("send_accepted", 32'(done), 1);
        break;
      end
    end
    ifc.pkt_valid = 1'b0;
  endtask

  task automatic waitDrain(input string name);
    int guard;
    guard = 0;
    while ((expQ[0].size() + expQ[1].size() + expQ[2].size()) != 0 && guard < 300) begin
      @(posedge clock); #1;
      guard++;
    end
    checkOutput(name, 32'(expQ[0].size() + expQ[1].size() + expQ[2].size()), 0);
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic addVec(input int idx, input int n, input logic [7:0] b0, input logic [7:0] b1,
                        input logic [7:0] b2, input logic [7:0] b3, input logic [7:0] b4,
                        input logic [7:0] b5, input int chan, input int expErr, input int expDrop);
    vecs[idx].bytes[0] = b0; vecs[idx].bytes[1] = b1; vecs[idx].bytes[2] = b2;
    vecs[idx].bytes[3] = b3; vecs[idx].bytes[4] = b4; vecs[idx].bytes[5] = b5;
    vecs[idx].n = n; vecs[idx].chan = chan;
    vecs[idx].expErr = expErr; vecs[idx].expDrop = expDrop;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, want completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int e0, d0, s0, guard, chan;
    logic [7:0] par, b;

    addVec(0, 5, 8'h0D, 8'h11, 8'h22, 8'h33, 8'h0D, 8'h00,  1, 0, 0);
    addVec(1, 5, 8'h0D, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00,  1, 1, 0);
    addVec(2, 3, 8'h07, 8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00, -1, 0, 1);
    addVec(3, 2, 8'h02, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00,  2, 0, 0);
    addVec(4, 3, 8'h04, 8'h5A, 8'h5E, 8'h00, 8'h00, 8'h00,  0, 0, 0);
    addVec(5, 4, 8'h0B, 8'h01, 8'h02, 8'h03, 8'h00, 8'h00, -1, 0, 1);
    addVec(6, 4, 8'h09, 8'hC3, 8'h3C, 8'hF6, 8'h00, 8'h00,  1, 0, 0);
    addVec(7, 2, 8'h02, 8'h03, 8'h00, 8'h00, 8'h00, 8'h00,  2, 1, 0);

    resetn = 1'b0;
    ifc.pkt_valid = 1'b0;
    ifc.data_in = '0;
    #12;
    checkOutput("reset_valid_out", 32'(ifc.valid_out), 0);
    checkOutput("reset_data_out", 32'(ifc.data_out), 0);
    checkOutput("reset_busy", 32'(ifc.busy), 0);
    checkOutput("reset_pulses", 32'({ifc.error, ifc.drop, ifc.soft_reset}), 0);
    @(posedge clock); #1;
    resetn = 1'b1;
    @(posedge clock); #1;

    // Table of whole packets, every channel read continuously.
    rdMask = '1;
    for (int v = 0; v < NVEC; v++) begin
      e0 = errCount;
      d0 = dropCount;
      chan = (vecs[v].chan < 0) ? 0 : vecs[v].chan;
      for (int k = 0; k < vecs[v].n; k++) applyStimulus(vecs[v].bytes[k], chan, vecs[v].chan >= 0);
      waitDrain($sformatf("vec%0d_drain", v));
      checkOutput($sformatf("vec%0d_error", v), 32'(errCount - e0), 32'(vecs[v].expErr));
      checkOutput($sformatf("vec%0d_drop", v), 32'(dropCount - d0), 32'(vecs[v].expDrop));
    end

    // Error pulse lands exactly in the cycle after the bad parity byte.
    applyStimulus(8'h0D, 1, 1'b1);
    applyStimulus(8'h11, 1, 1'b1);
    applyStimulus(8'h22, 1, 1'b1);
    applyStimulus(8'h33, 1, 1'b1);
    applyStimulus(8'h00, 1, 1'b1);
    @(negedge clock);
    checkOutput("err_pulse_high", 32'(ifc.error), 1);
    @(negedge clock);
    checkOutput("err_pulse_low", 32'(ifc.error), 0);
    waitDrain("err_seq_drain");

    // 20-byte packet into an unread channel 0 stalls at 16 entries.
    rdMask = '0;
    acceptCount = 0;
    e0 = errCount;
    fork
      begin
        par = 8'h48;
        applyStimulus(8'h48, 0, 1'b1);
        for (int k = 0; k < 18; k++) begin
          b = 8'(k * 13 + 5);
          par = par ^ b;
          applyStimulus(b, 0, 1'b1);
        end
        applyStimulus(par, 0, 1'b1);
      end
      begin
        guard = 0;
        do begin
          @(negedge clock);
          guard++;
        end while (!ifc.busy && guard < 100);
        checkOutput("busy_seen", 32'(ifc.busy), 1);
        checkOutput("busy_at_depth", 32'(acceptCount), 16);
        @(posedge clock); #1;
        rdMask = 3'b001;
      end
    join
    waitDrain("full_seq_drain");
    checkOutput("full_seq_error", 32'(errCount - e0), 0);

    // Channel 2 left unread for TIMEOUT cycles is flushed.
    rdMask = '0;
    s0 = softCount;
    applyStimulus(8'h02, 2, 1'b0);
    applyStimulus(8'h02, 2, 1'b0);
    repeat (TIMEOUT - 2) @(posedge clock);
    #1;
    checkOutput("to_still_valid", 32'(ifc.valid_out[2]), 1);
    checkOutput("to_no_soft_yet", 32'(ifc.soft_reset), 0);
    @(posedge clock); #1;
    checkOutput("to_flushed", 32'(ifc.valid_out[2]), 0);
    checkOutput("to_soft_pulse", 32'(ifc.soft_reset), 32'(3'b100));
    @(posedge clock); #1;
    checkOutput("to_soft_end", 32'(ifc.soft_reset), 0);
    checkOutput("to_soft_count", 32'(softCount - s0), 1);

    // A read in the 29th idle cycle keeps the channel alive.
    s0 = softCount;
    applyStimulus(8'h02, 2, 1'b1);
    applyStimulus(8'h02, 2, 1'b1);
    repeat (TIMEOUT - 3) @(posedge clock);
    #1;
    rdMask = 3'b100;
    checkOutput("nto_valid", 32'(ifc.valid_out[2]), 1);
    waitDrain("nto_drain");
    checkOutput("nto_soft_count", 32'(softCount - s0), 0);

    // Asynchronous reset in the middle of a payload.
    rdMask = '0;
    applyStimulus(8'h0D, 1, 1'b0);
    applyStimulus(8'h11, 1, 1'b0);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("arst_valid_out", 32'(ifc.valid_out), 0);
    checkOutput("arst_data_out", 32'(ifc.data_out), 0);
    checkOutput("arst_busy", 32'(ifc.busy), 0);
    @(posedge clock); #1;
    resetn = 1'b1;
    rdMask = '1;
    e0 = errCount;
    applyStimulus(8'h0D, 1, 1'b1);
    applyStimulus(8'h11, 1, 1'b1);
    applyStimulus(8'h22, 1, 1'b1);
    applyStimulus(8'h33, 1, 1'b1);
    applyStimulus(8'h0D, 1, 1'b1);
    waitDrain("arst_drain");
    checkOutput("arst_error", 32'(errCount - e0), 0);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end
endmodule
